// File: rtl/fixed_to_bcd.sv
// fixed_to_bcd: sequential 5.5 unsigned fixed-point to BCD converter (double-dabble integer, x10 fraction)
// Ports: CLOCK_50/reset (async active-high); in_value/in_valid/in_ready request handshake;
//        int_bcd (tens,ones), frac_bcd (FRAC_DIGITS digits, MS first), out_valid one-cycle pulse.
// Optional FIXED_TO_BCD_SEVENSEG_EN adds seg_int/seg_frac active-low g..a segment outputs.
module fixed_to_bcd #(
    parameter int FRAC_DIGITS = 3
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [9:0]               in_value,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               int_bcd,
    output logic [4*FRAC_DIGITS-1:0] frac_bcd,
    output logic                     out_valid
`ifdef FIXED_TO_BCD_SEVENSEG_EN
    ,
    output logic [13:0]              seg_int,
    output logic [7*FRAC_DIGITS-1:0] seg_frac
`endif
);
    localparam int FW = 4 * FRAC_DIGITS;
    typedef enum logic [1:0] {ST_IDLE, ST_INT, ST_FRAC, ST_PUBLISH} state_t;
    state_t          state_q, state_d;
    logic [4:0]      int_q, int_d, rem_q, rem_d;
    logic [7:0]      acc_q, acc_d, int_bcd_q, int_bcd_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [FW-1:0]   frac_q, frac_d, frac_bcd_q, frac_bcd_d;
    logic            out_valid_q, out_valid_d;
    logic [3:0]      hi, lo;
    logic [8:0]      p;
    // double-dabble correction applied before every shift
    assign hi = (acc_q[7:4] >= 4'd5) ? acc_q[7:4] + 4'd3 : acc_q[7:4];
    assign lo = (acc_q[3:0] >= 4'd5) ? acc_q[3:0] + 4'd3 : acc_q[3:0];
    // rem*10 over 32: the bits above the 5 fraction bits are the next decimal digit
    assign p  = {4'd0, rem_q} * 9'd10;
    always_comb begin
        state_d     = state_q;
        int_d       = int_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        frac_d      = frac_q;
        int_bcd_d   = int_bcd_q;
        frac_bcd_d  = frac_bcd_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                int_d   = in_value[9:5];
                rem_d   = in_value[4:0];
                acc_d   = 8'd0;
                cnt_d   = 3'd0;
                frac_d  = '0;
                state_d = ST_INT;
            end
            ST_INT: begin
                acc_d   = 8'({hi, lo, int_q[4]});
                int_d   = {int_q[3:0], 1'b0};
                cnt_d   = (cnt_q == 3'd4) ? 3'd0 : cnt_q + 3'd1;
                state_d = (cnt_q == 3'd4) ? ST_FRAC : ST_INT;
            end
            ST_FRAC: begin
                rem_d   = p[4:0];
                frac_d  = (frac_q << 4) | FW'(p[8:5]);
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == 3'(FRAC_DIGITS - 1)) ? ST_PUBLISH : ST_FRAC;
            end
            default: begin
                int_bcd_d   = acc_q;
                frac_bcd_d  = frac_q;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            int_q       <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            frac_q      <= '0;
            int_bcd_q   <= '0;
            frac_bcd_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            int_q       <= int_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            frac_q      <= frac_d;
            int_bcd_q   <= int_bcd_d;
            frac_bcd_q  <= frac_bcd_d;
            out_valid_q <= out_valid_d;
        end
    end
    assign in_ready  = (state_q == ST_IDLE);
    assign int_bcd   = int_bcd_q;
    assign frac_bcd  = frac_bcd_q;
    assign out_valid = out_valid_q;
`ifdef FIXED_TO_BCD_SEVENSEG_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction
    logic [13:0]              seg_int_q, seg_int_d;
    logic [7*FRAC_DIGITS-1:0] seg_frac_q, seg_frac_d;
    always_comb begin
        seg_int_d  = seg_int_q;
        seg_frac_d = seg_frac_q;
        if (state_q == ST_PUBLISH) begin
            seg_int_d = {(acc_q[7:4] == 4'd0) ? 7'h7F : seg7(acc_q[7:4]), seg7(acc_q[3:0])};
            for (int i = 0; i < FRAC_DIGITS; i++) seg_frac_d[7*i +: 7] = seg7(frac_q[4*i +: 4]);
        end
    end
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            seg_int_q  <= '1;
            seg_frac_q <= '1;
        end else begin
            seg_int_q  <= seg_int_d;
            seg_frac_q <= seg_frac_d;
        end
    end
    assign seg_int  = seg_int_q;
    assign seg_frac = seg_frac_q;
`endif
endmodule

// File: tb/tb_fixed_to_bcd.sv
// tb_fixed_to_bcd: self-checking bench for fixed_to_bcd (table vectors, random vs arithmetic model, corner sequences)
module tb_fixed_to_bcd;
    localparam int FD = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [9:0] in_value = '0;
    logic in_valid = 1'b0;
    logic in_ready, out_valid;
    logic [7:0] int_bcd;
    logic [4*FD-1:0] frac_bcd;
`ifdef FIXED_TO_BCD_SEVENSEG_EN
    logic [13:0] seg_int;
    logic [7*FD-1:0] seg_frac;
`endif
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    fixed_to_bcd #(.FRAC_DIGITS(FD)) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .in_value(in_value),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .int_bcd(int_bcd),
        .frac_bcd(frac_bcd),
        .out_valid(out_valid)
`ifdef FIXED_TO_BCD_SEVENSEG_EN
        ,
        .seg_int(seg_int),
        .seg_frac(seg_frac)
`endif
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    function automatic logic [7:0] m_int(input logic [9:0] v);
        int n = int'(v) / 32;
        return {4'(n / 10), 4'(n % 10)};
    endfunction
    // exact fraction is k*0.03125 = k*3125 / 100000; drop trailing digits to truncate
    function automatic logic [4*FD-1:0] m_frac(input logic [9:0] v);
        int f = (int'(v) % 32) * 3125;
        logic [4*FD-1:0] r;
        for (int i = 0; i < 5 - FD; i++) f = f / 10;
        for (int i = 0; i < FD; i++) begin
            r[4*i +: 4] = 4'(f % 10);
            f = f / 10;
        end
        return r;
    endfunction
`ifdef FIXED_TO_BCD_SEVENSEG_EN
    function automatic logic [6:0] m_seg(input logic [3:0] d);
        logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[d];
    endfunction
`endif
    task automatic check_result(input logic [9:0] v, input string tag);
        logic [7:0] ei = m_int(v);
        logic [4*FD-1:0] ef = m_frac(v);
        chk({tag, " int_bcd"}, 32'(int_bcd), 32'(ei));
        chk({tag, " frac_bcd"}, 32'(frac_bcd), 32'(ef));
`ifdef FIXED_TO_BCD_SEVENSEG_EN
        begin
            logic [13:0] es = {(ei[7:4] == 4'd0) ? 7'h7F : m_seg(ei[7:4]), m_seg(ei[3:0])};
            logic [7*FD-1:0] esf;
            for (int i = 0; i < FD; i++) esf[7*i +: 7] = m_seg(ef[4*i +: 4]);
            chk({tag, " seg_int"}, 32'(seg_int), 32'(es));
            chk({tag, " seg_frac"}, 32'(seg_frac), 32'(esf));
        end
`endif
    endtask
    // one request held for a single cycle; checks latency, busy in_ready, pulse width and digits
    task automatic convert(input logic [9:0] v, input string tag);
        int n = 0;
        int busy_bad = 0;
        @(negedge clk);
        chk({tag, " ready_before"}, 32'(in_ready), 32'd1);
        in_value = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_value = 10'($urandom);
        @(negedge clk);
        while (!out_valid && n < 40) begin
            if (in_ready) busy_bad++;
            in_value = 10'($urandom);
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(6 + FD));
        chk({tag, " busy_ready"}, 32'(busy_bad), 32'd0);
        chk({tag, " ready_at_pulse"}, 32'(in_ready), 32'd1);
        check_result(v, tag);
        @(negedge clk);
        chk({tag, " pulse_width"}, 32'(out_valid), 32'd0);
        check_result(v, {tag, " hold"});
    endtask
    typedef struct {
        logic [9:0]      v;
        logic [7:0]      ib;
        logic [4*FD-1:0] fb;
    } vec_t;
    initial begin
        vec_t vecs [9];
        logic [9:0] q [$];
        int acc_cyc [$];
        vecs[0] = '{10'd32,   8'h01, 12'h000};
        vecs[1] = '{10'd87,   8'h02, 12'h718};
        vecs[2] = '{10'd1023, 8'h31, 12'h968};
        vecs[3] = '{10'd0,    8'h00, 12'h000};
        vecs[4] = '{10'd1,    8'h00, 12'h031};
        vecs[5] = '{10'd31,   8'h00, 12'h968};
        vecs[6] = '{10'd160,  8'h05, 12'h000};
        vecs[7] = '{10'd320,  8'h10, 12'h000};
        vecs[8] = '{10'd304,  8'h09, 12'h500};
        #2;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset int_bcd", 32'(int_bcd), 32'd0);
        chk("reset frac_bcd", 32'(frac_bcd), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
`ifdef FIXED_TO_BCD_SEVENSEG_EN
        chk("reset seg_int", 32'(seg_int), 32'h3FFF);
        chk("reset seg_frac", 32'(seg_frac), 32'((1 << (7 * FD)) - 1));
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            convert(vecs[i].v, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d table_int", i), 32'(int_bcd), 32'(vecs[i].ib));
            chk($sformatf("vec%0d table_frac", i), 32'(frac_bcd), 32'(vecs[i].fb));
        end
        for (int i = 0; i < 20; i++) convert(10'($urandom), $sformatf("rand%0d", i));
        // busy: in_valid held high, in_value changes every cycle
        for (int c = 0; c < 46; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() > 0) check_result(q.pop_front(), $sformatf("busy c%0d", c));
                else chk("busy spurious_out_valid", 32'd1, 32'd0);
            end
            if (c < 40) begin
                in_valid = 1'b1;
                in_value = 10'($urandom);
                if (in_ready) begin
                    q.push_back(in_value);
                    acc_cyc.push_back(c);
                end
            end else in_valid = 1'b0;
        end
        chk("busy accepts", 32'(acc_cyc.size()), 32'd4);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk($sformatf("busy spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(7 + FD));
        chk("busy drained", 32'(q.size()), 32'd0);
        // prime outputs with nonzero values, then abort a conversion with reset
        convert(10'd1023, "pre_abort");
        @(negedge clk);
        in_value = 10'd87;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        in_value = 10'd1023;
        in_valid = 1'b1;
        #1;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort int_bcd", 32'(int_bcd), 32'd0);
        chk("abort frac_bcd", 32'(frac_bcd), 32'd0);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("abort ignore in_valid ready", 32'(in_ready), 32'd1);
        chk("abort ignore in_valid int", 32'(int_bcd), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        begin
            int pulses = 0;
            for (int c = 0; c < 15; c++) begin
                @(negedge clk);
                if (out_valid) pulses++;
            end
            chk("abort no_out_valid", 32'(pulses), 32'd0);
        end
        convert(10'd32, "post_abort");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
